// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file write path.
//   - default width/count constants used as parameter defaults
//   - regfile_wr_req_t: one write request {addr, data} at default widths
//   - wrap_inc: modular increment used by the rotating-priority scan
package regfile_pkg;

    localparam int N_REQ_DEF         = 4;
    localparam int N_WRITE_PORTS_DEF = 2;
    localparam int ENTRY_WIDTH_DEF   = 32;
    localparam int N_ENTRIES_DEF     = 32;
    localparam int PTR_WIDTH_DEF     = $clog2(N_ENTRIES_DEF);

    typedef struct packed {
        logic [PTR_WIDTH_DEF-1:0]   addr;
        logic [ENTRY_WIDTH_DEF-1:0] data;
    } regfile_wr_req_t;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arb_pick.sv
// regfile_wr_arb_pick: combinational rotating-priority, conflict-free picker.
// Scans requesters starting at rr_ptr_i and picks up to N_WRITE_PORTS valid
// requests with pairwise distinct addresses, filling slots in scan order.
// Ports:
//   rr_ptr_i    current highest-priority requester
//   valid_i     request pending per requester
//   addr_i      destination register per requester
//   hold_i      suppress every pick
//   ready_o     requester accepted this cycle
//   slot_en_o   slot carries a write
//   slot_sel_o  requester index feeding each slot
//   rr_nxt_o    next rr_ptr (last picked + 1, or unchanged when nothing picked)
// Option REGFILE_WR_ARB_X0_DROP_EN: writes to register 0 are acknowledged
// without using a slot, without conflict checks and without moving rr_ptr.
module regfile_wr_arb_pick
    import regfile_pkg::*;
#(
    parameter int N_REQ         = N_REQ_DEF,
    parameter int N_WRITE_PORTS = N_WRITE_PORTS_DEF,
    parameter int PTR_WIDTH     = PTR_WIDTH_DEF,
    parameter int IW            = $clog2(N_REQ)
) (
    input  logic [IW-1:0]                          rr_ptr_i,
    input  logic [N_REQ-1:0]                       valid_i,
    input  logic [N_REQ-1:0][PTR_WIDTH-1:0]        addr_i,
    input  logic                                   hold_i,
    output logic [N_REQ-1:0]                       ready_o,
    output logic [N_WRITE_PORTS-1:0]               slot_en_o,
    output logic [N_WRITE_PORTS-1:0][IW-1:0]       slot_sel_o,
    output logic [IW-1:0]                          rr_nxt_o
);

    logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0] slot_addr;
    int                                      cnt;
    int                                      idx;
    logic [IW-1:0]                           idx_l;
    logic                                    hit;
    logic                                    drop;

    always_comb begin
        ready_o    = '0;
        slot_en_o  = '0;
        slot_sel_o = '0;
        slot_addr  = '0;
        rr_nxt_o   = rr_ptr_i;
        cnt        = 0;
        idx        = 0;
        idx_l      = '0;
        hit        = 1'b0;
        drop       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_l = IW'(idx);
            if (!hold_i && valid_i[idx_l]) begin
                drop = 1'b0;
`ifdef REGFILE_WR_ARB_X0_DROP_EN
                drop = (addr_i[idx_l] == '0);
`endif
                if (drop) begin
                    ready_o[idx_l] = 1'b1;
                end else begin
                    // Only slots already filled this cycle take part in the
                    // address check; first in scan order wins a collision.
                    hit = 1'b0;
                    for (int s = 0; s < N_WRITE_PORTS; s++)
                        if (s < cnt && slot_addr[s] == addr_i[idx_l]) hit = 1'b1;
                    if (!hit && cnt < N_WRITE_PORTS) begin
                        ready_o[idx_l] = 1'b1;
                        for (int s = 0; s < N_WRITE_PORTS; s++) begin
                            if (s == cnt) begin
                                slot_en_o[s]  = 1'b1;
                                slot_sel_o[s] = idx_l;
                                slot_addr[s]  = addr_i[idx_l];
                            end
                        end
                        cnt      = cnt + 1;
                        rr_nxt_o = IW'(wrap_inc(idx, N_REQ));
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: shares the register file write ports between writeback
// requesters with valid/ready handshakes and rotating priority. Accepted
// writes are registered and appear on wr_* one cycle after acceptance.
// Ports:
//   clk, rst_aL            clock, asynchronous active-low reset
//   req_valid/addr/data    requester side; req_ready is combinational
//   hold                   suppress all grants this cycle
//   wr_en/addr/data        registered register-file write ports
//   rr_ptr                 registered highest-priority requester
// Option REGFILE_WR_ARB_X0_DROP_EN (see regfile_wr_arb_pick): register 0
// writes are acknowledged and discarded.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int  N_REQ         = N_REQ_DEF,
    parameter int  N_WRITE_PORTS = N_WRITE_PORTS_DEF,
    parameter int  ENTRY_WIDTH   = ENTRY_WIDTH_DEF,
    parameter int  N_ENTRIES     = N_ENTRIES_DEF,
    localparam int PTR_WIDTH     = $clog2(N_ENTRIES),
    localparam int IW            = $clog2(N_REQ)
) (
    input  logic                                     clk,
    input  logic                                     rst_aL,
    input  logic [N_REQ-1:0]                         req_valid,
    input  logic [N_REQ-1:0][PTR_WIDTH-1:0]          req_addr,
    input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]        req_data,
    output logic [N_REQ-1:0]                         req_ready,
    input  logic                                     hold,
    output logic [N_WRITE_PORTS-1:0]                 wr_en,
    output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  wr_addr,
    output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data,
    output logic [IW-1:0]                            rr_ptr
);

    logic [N_WRITE_PORTS-1:0]                  wr_en_q,   wr_en_d;
    logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [IW-1:0]                             rr_ptr_q,  rr_ptr_d;
    logic [N_WRITE_PORTS-1:0][IW-1:0]          slot_sel;

    // Reset acts like hold so req_ready is low while rst_aL is asserted.
    regfile_wr_arb_pick #(
        .N_REQ        (N_REQ),
        .N_WRITE_PORTS(N_WRITE_PORTS),
        .PTR_WIDTH    (PTR_WIDTH),
        .IW           (IW)
    ) u_pick (
        .rr_ptr_i  (rr_ptr_q),
        .valid_i   (req_valid),
        .addr_i    (req_addr),
        .hold_i    (hold | ~rst_aL),
        .ready_o   (req_ready),
        .slot_en_o (wr_en_d),
        .slot_sel_o(slot_sel),
        .rr_nxt_o  (rr_ptr_d)
    );

    always_comb begin
        wr_addr_d = '0;
        wr_data_d = '0;
        for (int s = 0; s < N_WRITE_PORTS; s++) begin
            wr_addr_d[s] = req_addr[slot_sel[s]];
            wr_data_d[s] = req_data[slot_sel[s]];
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model
// and a shadow register file. Honors REGFILE_WR_ARB_X0_DROP_EN.
module tb_regfile_wr_arb;
    import regfile_pkg::*;

    localparam int N_REQ = 4;
    localparam int NWP   = 2;
    localparam int EW    = 32;
    localparam int NE    = 32;
    localparam int PW    = $clog2(NE);
    localparam int IW    = $clog2(N_REQ);
`ifdef REGFILE_WR_ARB_X0_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst_aL = 1'b0;
    logic                          hold = 1'b0;
    logic [N_REQ-1:0]              req_valid, req_ready;
    logic [N_REQ-1:0][PW-1:0]      req_addr;
    logic [N_REQ-1:0][EW-1:0]      req_data;
    logic [NWP-1:0]                wr_en;
    logic [NWP-1:0][PW-1:0]        wr_addr;
    logic [NWP-1:0][EW-1:0]        wr_data;
    logic [IW-1:0]                 rr_ptr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wr_arb #(
        .N_REQ(N_REQ), .N_WRITE_PORTS(NWP), .ENTRY_WIDTH(EW), .N_ENTRIES(NE)
    ) dut (
        .clk(clk), .rst_aL(rst_aL),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .hold(hold),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rr_ptr(rr_ptr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int             m_rr;
    logic [NWP-1:0] exp_en;
    logic [PW-1:0]  exp_addr[NWP];
    logic [EW-1:0]  exp_data[NWP];
    logic [EW-1:0]  dut_rf[NE];
    logic [EW-1:0]  mdl_rf[NE];
    logic [N_REQ-1:0] fired;

    always @(negedge clk) begin : cmp
        int picks[$];
        logic [N_REQ-1:0] rdy;
        int nrr;
        if (!rst_aL) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_rr", rr_ptr, 0);
            m_rr = 0;
            exp_en = '0;
            for (int s = 0; s < NWP; s++) begin exp_addr[s] = '0; exp_data[s] = '0; end
            fired = '0;
        end else begin
            picks.delete();
            rdy = '0;
            nrr = m_rr;
            if (!hold) begin
                for (int k = 0; k < N_REQ; k++) begin
                    int i;
                    bit clash;
                    i = (m_rr + k) % N_REQ;
                    if (!req_valid[i]) continue;
                    if (DROP && req_addr[i] == 0) begin rdy[i] = 1'b1; continue; end
                    clash = 0;
                    foreach (picks[p]) if (req_addr[picks[p]] == req_addr[i]) clash = 1;
                    if (!clash && picks.size() < NWP) begin
                        picks.push_back(i);
                        rdy[i] = 1'b1;
                        nrr = (i + 1) % N_REQ;
                    end
                end
            end
            chk("ready", req_ready, rdy);
            chk("wr_en", wr_en, exp_en);
            for (int s = 0; s < NWP; s++) begin
                if (exp_en[s]) begin
                    chk("wr_addr", wr_addr[s], exp_addr[s]);
                    chk("wr_data", wr_data[s], exp_data[s]);
                end
            end
            chk("rr_ptr", rr_ptr, m_rr);
            // outputs presented now land in the register file this cycle
            for (int s = 0; s < NWP; s++) begin
                if (wr_en[s])  dut_rf[wr_addr[s]]  = wr_data[s];
                if (exp_en[s]) mdl_rf[exp_addr[s]] = exp_data[s];
            end
            exp_en = '0;
            foreach (picks[p]) begin
                exp_en[p]   = 1'b1;
                exp_addr[p] = req_addr[picks[p]];
                exp_data[p] = req_data[picks[p]];
            end
            m_rr  = nrr;
            fired = req_valid & req_ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    initial begin
        for (int r = 0; r < NE; r++) begin dut_rf[r] = '0; mdl_rf[r] = '0; end
        req_valid = '0; req_addr = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        smp();
        chk("reset_ready", req_ready, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_rr", rr_ptr, 0);
        cyc(); rst_aL = 1'b1;

        // full load
        cyc();
        req_valid = 4'b1111;
        for (int i = 0; i < N_REQ; i++) begin req_addr[i] = PW'(i + 1); req_data[i] = 100 + i; end
        smp(); chk("full_rdy0", req_ready, 4'b0011);
        cyc(); req_valid = 4'b1100;
        smp();
        chk("full_en1", wr_en, 2'b11);
        chk("full_a0", wr_addr[0], 1); chk("full_a1", wr_addr[1], 2);
        chk("full_d1", wr_data[1], 101);
        chk("full_rr1", rr_ptr, 2); chk("full_rdy1", req_ready, 4'b1100);
        cyc(); req_valid = '0;
        smp();
        chk("full_a2", wr_addr[0], 3); chk("full_a3", wr_addr[1], 4); chk("full_rr2", rr_ptr, 0);

        // same-address collision
        cyc();
        req_valid = 4'b0111;
        req_addr[0] = 5; req_data[0] = 32'hAAAA0000;
        req_addr[1] = 5; req_data[1] = 32'hBBBB0000;
        req_addr[2] = 6; req_data[2] = 32'h66660000;
        smp(); chk("col_rdy0", req_ready, 4'b0101);
        cyc(); req_valid = 4'b0010;
        smp();
        chk("col_rdy1", req_ready, 4'b0010); chk("col_en1", wr_en, 2'b11);
        chk("col_a0", wr_addr[0], 5); chk("col_d0", wr_data[0], 32'hAAAA0000);
        chk("col_a1", wr_addr[1], 6); chk("col_rr1", rr_ptr, 3);
        cyc(); req_valid = '0;
        smp();
        chk("col_en2", wr_en, 2'b01); chk("col_d2", wr_data[0], 32'hBBBB0000);
        cyc(); smp();
        chk("col_reg5", dut_rf[5], 32'hBBBB0000);

        // hold (rr_ptr is 2 here)
        cyc();
        req_valid = 4'b1111; hold = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin req_addr[i] = PW'(10 + i); req_data[i] = 200 + i; end
        smp(); chk("hold_rdy0", req_ready, 0); chk("hold_rr0", rr_ptr, 2);
        cyc(); smp();
        chk("hold_rdy1", req_ready, 0); chk("hold_en1", wr_en, 0); chk("hold_rr1", rr_ptr, 2);
        cyc(); hold = 1'b0;
        smp(); chk("hold_rdy2", req_ready, 4'b1100); chk("hold_en2", wr_en, 0);
        cyc(); req_valid = 4'b0011;
        smp();
        chk("hold_en3", wr_en, 2'b11); chk("hold_a30", wr_addr[0], 12); chk("hold_a31", wr_addr[1], 13);
        chk("hold_rdy3", req_ready, 4'b0011);
        cyc(); req_valid = '0;
        smp(); chk("hold_rr4", rr_ptr, 2);

        // wrap: steer rr_ptr to 3 by granting req2 alone
        cyc(); req_valid = 4'b0100; req_addr[2] = 20; req_data[2] = 300;
        smp();
        cyc();
        req_valid = 4'b1001;
        req_addr[0] = 21; req_data[0] = 321;
        req_addr[3] = 22; req_data[3] = 322;
        smp(); chk("wrap_rr0", rr_ptr, 3); chk("wrap_rdy", req_ready, 4'b1001);
        cyc(); req_valid = '0;
        smp();
        chk("wrap_en", wr_en, 2'b11);
        chk("wrap_a0", wr_addr[0], 22); chk("wrap_a1", wr_addr[1], 21); chk("wrap_rr1", rr_ptr, 1);

        // register-0 handling; steer rr_ptr to 0 by granting req3 alone
        cyc(); req_valid = 4'b1000; req_addr[3] = 23; req_data[3] = 323;
        smp();
        cyc();
        req_valid = 4'b0111;
        req_addr[0] = 0; req_data[0] = 32'h0D0D0000;
        req_addr[1] = 7; req_data[1] = 407;
        req_addr[2] = 8; req_data[2] = 408;
        smp(); chk("x0_rr", rr_ptr, 0);
        chk("x0_rdy", req_ready, DROP ? 4'b0111 : 4'b0011);
        cyc(); req_valid = DROP ? 4'b0000 : 4'b0100;
        smp();
        chk("x0_en", wr_en, 2'b11);
        chk("x0_a0", wr_addr[0], DROP ? 7 : 0);
        chk("x0_a1", wr_addr[1], DROP ? 8 : 7);
        cyc(); req_valid = '0;
        smp();
        cyc(); smp();
        chk("x0_reg0", dut_rf[0], DROP ? 32'h0 : 32'h0D0D0000);

        // randomized traffic with a mid-stream reset
        for (int n = 0; n < 600; n++) begin
            cyc();
            if (n == 300) begin
                rst_aL = 1'b0;
                smp();
                chk("mid_rst_ready", req_ready, 0);
                chk("mid_rst_wr_en", wr_en, 0);
                chk("mid_rst_rr", rr_ptr, 0);
                continue;
            end
            if (n == 301) continue;
            if (n == 302) rst_aL = 1'b1;
            for (int i = 0; i < N_REQ; i++) begin
                if (fired[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_addr[i]  = PW'($urandom_range(0, 7));
                    req_data[i]  = $urandom;
                end
            end
            hold = ($urandom_range(0, 7) == 0);
            if (n == 302) begin
                hold = 1'b0;
                if (!req_valid[0]) begin
                    req_valid[0] = 1'b1;
                    req_addr[0]  = PW'($urandom_range(1, 7));
                end
                smp();
                chk("post_rst_req0", req_ready[0], 1'b1);
            end
        end
        cyc(); req_valid = '0; hold = 1'b0;
        repeat (3) cyc();
        smp();
        for (int r = 0; r < NE; r++) chk("regfile", dut_rf[r], mdl_rf[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Write-port arbiter and sequencer for the multi-ported register file. It shares the register file's `N_WRITE_PORTS` write ports between `N_REQ` writeback requesters (functional units, load return, CSR path) using valid/ready handshakes and rotating priority. It guarantees that no two write ports carry the same address in one cycle, which the register file requires. Granted writes are registered and drive the register file write ports one cycle after acceptance.

## Interface
Parameters:
- `N_REQ`, 4, number of writeback requesters
- `N_WRITE_PORTS`, 2, register file write ports driven
- `ENTRY_WIDTH`, 32, data width
- `N_ENTRIES`, 32, register count; `PTR_WIDTH` = $clog2(N_ENTRIES), localparam

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst_aL`  in  1  asynchronous, active-low reset
- `req_valid`  in  [N_REQ]  request pending
- `req_addr`  in  [N_REQ][PTR_WIDTH]  destination register
- `req_data`  in  [N_REQ][ENTRY_WIDTH]  write data
- `req_ready`  out  [N_REQ]  request accepted this cycle (combinational)
- `hold`  in  1  suppress all grants this cycle
- `wr_en`  out  [N_WRITE_PORTS]  to register file, registered
- `wr_addr`  out  [N_WRITE_PORTS][PTR_WIDTH]  to register file, registered
- `wr_data`  out  [N_WRITE_PORTS][ENTRY_WIDTH]  to register file, registered
- `rr_ptr`  out  [$clog2(N_REQ)]  current highest-priority requester, registered

## Operation
- Scan order each cycle: rr_ptr, rr_ptr+1, … mod N_REQ.
- A requester is picked if all of the following hold:
  - it is valid;
  - its addr differs from every addr already picked this cycle;
  - fewer than N_WRITE_PORTS have been picked so far.
- Picked requesters get `req_ready`=1. A transfer occurs on valid && ready.
- Picks fill write slots 0, 1, … in scan order. Unused slots get `wr_en`=0.
- Same-address collision: the first requester in scan order wins. The others stay un-ready and retry in later cycles.
- Requesters hold valid/addr/data stable until ready. Valid never depends on ready.
- `rr_ptr` update:
  - if ≥1 grant, rr_ptr ← (index of last picked + 1) mod N_REQ;
  - if no grant, it is unchanged.
- `hold`=1 gives all `req_ready`=0, no grants, rr_ptr unchanged, and next-cycle `wr_en`=0.
- `req_ready` is forced to 0 while `rst_aL`=0.
- Reset mid-operation discards the output stage. Writes already accepted but not yet applied by the register file are lost. The system resets both blocks together.

## Timing
- Acceptance in cycle N produces `wr_en`/`wr_addr`/`wr_data` valid in cycle N+1. The register file state is updated at the end of N+1.
- Throughput: up to N_WRITE_PORTS writes per cycle, sustained.
- Ordering: writes to the same address accepted in different cycles reach the register file in acceptance order.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rr_ptr`=0. `req_ready`=0 during reset.
- No combinational path from `req_*` to `wr_*`.

## Configuration
- Macro `REGFILE_WR_ARB_X0_DROP_EN`.
- Defined: a valid request with addr 0 is always ready, except under hold or reset. It occupies no write slot, is excluded from address-conflict checks, does not affect rr_ptr, and never raises `wr_en`.
- Undefined: addr 0 is arbitrated and written like any other address.

## Structure
- Shared package `regfile_pkg`:
  - `regfile_wr_req_t` struct {addr, data};
  - default width constants;
  - `N_WRITE_PORTS` default.
- Sub-module `regfile_wr_arb_pick`: purely combinational rotating-priority, conflict-free N-of-M picker. Inputs are rr_ptr, valid, addr and hold. Outputs are ready, per-slot select index plus enable, and the next rr_ptr. The top level holds only the output-stage and rr_ptr flops.

## Test plan
Default parameters (N_REQ=4, 2 ports).
1. Reset: assert `rst_aL`=0 during traffic → all `wr_en`=0, `req_ready`=0, `rr_ptr`=0 immediately; after release, first grant starts at requester 0.
2. Full load: all valid, addrs 1,2,3,4, rr_ptr=0.
   - Cycle 0: ready=4'b0011.
   - Cycle 1: `wr_en`=2'b11, `wr_addr`={1,2}, rr_ptr=2, ready=4'b1100.
   - Cycle 2: `wr_addr`={3,4}.
3. Collision: req0 addr5/data A, req1 addr5/data B, req2 addr6, rr_ptr=0.
   - Cycle 0: grant 0 and 2.
   - Cycle 1: req1 granted alone.
   - Register 5 ends with B.
4. Hold: all valid, `hold`=1 for 2 cycles → ready=0, `wr_en`=0 one cycle later, rr_ptr unchanged; grants resume when hold drops.
5. Wrap: rr_ptr=3, only req3 and req0 valid → both granted, slot0=req3, slot1=req0, rr_ptr becomes 1.
6. With `REGFILE_WR_ARB_X0_DROP_EN`: req0 addr0, req1 addr7, req2 addr8 → all three ready in one cycle, `wr_addr`={7,8}, no write to register 0. Without the macro: req0 and req1 granted, `wr_addr`={0,7}.
